// File: rtl/uart_echo_tester_if.sv
// Control/status handshake and serial lines of the UART echo tester.
// The slave modport is the tester's view; the master modport is the host/bench view.
interface uart_echo_tester_if;
  logic       start;
  logic       rx;
  logic       tx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       timeout;

  modport master (output start, rx, input tx, busy, done, pass, err_count, timeout);
  modport slave  (input start, rx, output tx, busy, done, pass, err_count, timeout);
endinterface

// File: rtl/uart_echo_tester.sv
// UART echo tester: sends SEED, SEED+1, ... as 8N1 on tx and checks the echo on rx.
// Define UART_ECHO_TIMEOUT_EN to build the idle-receive watchdog.
module uart_echo_tester #(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned MSG_LEN        = 16,
  parameter logic [7:0]  SEED           = 8'h41,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst_n,
  uart_echo_tester_if.slave bus
);
  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    LEN       = 8'(MSG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE}          top_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  top_state_e    top_state_q, top_state_d;
  tx_state_e     tx_state_q, tx_state_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          pass_q, pass_d, tx_q, tx_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  logic       run_go, tx_bit_end, rx_bit_end, rx_done, rx_bad, run_last;
  logic       wd_expire, timeout_hit;
  logic [7:0] tx_idx_next, rx_idx_inc, rx_expect;

  assign run_go      = (top_state_q == S_IDLE) && bus.start;
  assign tx_bit_end  = (tx_cnt_q == BIT_LAST);
  assign rx_bit_end  = (rx_cnt_q == BIT_LAST);
  assign tx_idx_next = tx_idx_q + 8'd1;
  assign rx_idx_inc  = rx_idx_q + 8'd1;
  assign rx_expect   = SEED + rx_idx_q;
  assign rx_done     = (rx_state_q == R_STOP) && rx_bit_end;
  // A wrong data byte and a low stop bit count the same way.
  assign rx_bad      = (rx_shift_q != rx_expect) || !rx_sync_q;
  assign run_last    = rx_done && (rx_idx_inc == LEN);
  assign timeout_hit = wd_expire && !run_last;

  // ---------------- transmitter ----------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    if (tx_state_q != T_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      T_IDLE: if (run_go) begin
        tx_state_d = T_START;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_shift_d = SEED;
      end
      T_START: if (tx_bit_end) begin
        tx_state_d = T_DATA;
        tx_bit_d   = '0;
      end
      T_DATA: if (tx_bit_end) begin
        tx_shift_d = {1'b1, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
      end
      T_STOP: if (tx_bit_end) begin
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (tx_idx_next < LEN) begin
          tx_state_d = T_START;
          tx_idx_d   = tx_idx_next;
          tx_shift_d = SEED + tx_idx_next;
        end else begin
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
    unique case (tx_state_d)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      R_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = R_START;
        rx_cnt_d   = '0;
      end
      R_START: if (rx_cnt_q == HALF_LAST) begin
        // Still low at mid-bit: a real start bit; high means a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
      R_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
      R_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_state_d = R_IDLE;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------- run control and checker ----------------
  always_comb begin
    top_state_d = top_state_q;
    rx_idx_d    = rx_idx_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    unique case (top_state_q)
      S_IDLE: if (bus.start) begin
        top_state_d = S_RUN;
        rx_idx_d    = '0;
        err_count_d = '0;
        pass_d      = 1'b0;
      end
      S_RUN: begin
        if (rx_done) begin
          rx_idx_d = rx_idx_inc;
          if (rx_bad && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
        if (run_last || wd_expire) begin
          top_state_d = S_DONE;
          pass_d      = (err_count_d == 8'd0) && !timeout_hit;
        end
      end
      S_DONE:  top_state_d = S_IDLE;
      default: top_state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_state_q <= S_IDLE;
      tx_state_q  <= T_IDLE;
      rx_state_q  <= R_IDLE;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      rx_bit_q    <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_idx_q    <= '0;
      rx_idx_q    <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
      tx_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      top_state_q <= top_state_d;
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      rx_bit_q    <= rx_bit_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
      tx_q        <= tx_d;
      rx_meta_q   <= bus.rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
    end
  end

`ifdef UART_ECHO_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;

  assign wd_expire = (top_state_q == S_RUN) && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (run_go) begin
      wd_d      = '0;
      timeout_d = 1'b0;
    end else if (top_state_q == S_RUN) begin
      wd_d = rx_done ? '0 : wd_q + 1'b1;
      if (timeout_hit) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expire          = 1'b0;
  assign bus.timeout        = 1'b0;
`endif

  assign bus.tx        = tx_q;
  assign bus.busy      = (top_state_q == S_RUN);
  assign bus.done      = (top_state_q == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: loopback, corrupted echoes, framing error,
// missing echo, mid-run restart/reset, and pattern wrap on a second instance.
module tb_uart_echo_tester;
  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  logic loop_a;
  logic rx_drv;
  int   n_checks;
  int   n_errors;
  logic [7:0] tx_seen[$];

  uart_echo_tester_if bus_a ();
  uart_echo_tester_if bus_b ();

  uart_echo_tester #(.CLKS_PER_BIT(CPB), .MSG_LEN(4), .SEED(8'h41), .TIMEOUT_CYCLES(4096))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  uart_echo_tester #(.CLKS_PER_BIT(CPB), .MSG_LEN(3), .SEED(8'hFE), .TIMEOUT_CYCLES(4096))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.rx = loop_a ? bus_a.tx : rx_drv;
  assign bus_b.rx = bus_b.tx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    if (sel_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int limit, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      seen = sel_b ? bus_b.done : bus_a.done;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
    rx_drv = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (CPB) tick();
    end
    rx_drv = stop_bit;
    repeat (CPB) tick();
    rx_drv = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic check_tx_bytes();
    check("tx_count", tx_seen.size(), 4);
    if (tx_seen.size() == 4)
      for (int i = 0; i < 4; i++) check("tx_byte", tx_seen[i], 32'h41 + i);
  endtask

  // Decodes bytes appearing on dut_a's tx by mid-bit sampling.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge bus_a.tx);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (bus_a.tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = bus_a.tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        tx_seen.push_back(b);
      end
    end
  end

  initial begin : stim
    int cyc;
    int total;
    int extra;
    bit seen;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    loop_a      = 1'b1;
    rx_drv      = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_tx", bus_a.tx, 1);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_pass", bus_a.pass, 0);
    check("rst_err", bus_a.err_count, 0);
    check("rst_timeout", bus_a.timeout, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Loopback run with an ignored second start during byte 1
    tx_seen.delete();
    pulse_start(1'b0);
    check("start_busy", bus_a.busy, 1);
    check("start_tx_low", bus_a.tx, 0);
    repeat (200) tick();
    pulse_start(1'b0);
    check("restart_busy", bus_a.busy, 1);
    wait_done(1'b0, 1000, cyc, seen);
    total = 201 + cyc;
    check("loop_done_seen", seen, 1);
    check("loop_done_time_ok", (total >= 630 && total <= 650), 1);
    check("loop_busy_at_done", bus_a.busy, 0);
    check("loop_pass", bus_a.pass, 1);
    check("loop_err", bus_a.err_count, 0);
    check("loop_timeout", bus_a.timeout, 0);
    extra = 0;
    repeat (60) begin
      tick();
      if (bus_a.done) extra++;
    end
    check("loop_single_done", extra, 0);
    check("loop_pass_held", bus_a.pass, 1);
    check_tx_bytes();

    // Echo with bit 0 of byte 2 flipped
    loop_a = 1'b0;
    pulse_start(1'b0);
    fork
      begin
        send_frame(8'h41, 1'b1, 0);
        send_frame(8'h42, 1'b1, 0);
        send_frame(8'h42, 1'b1, 0);
        send_frame(8'h44, 1'b1, 0);
      end
      wait_done(1'b0, 1000, cyc, seen);
    join
    check("flip_done_seen", seen, 1);
    check("flip_err", bus_a.err_count, 1);
    check("flip_pass", bus_a.pass, 0);
    repeat (200) tick();

    // Framing error on byte 0
    pulse_start(1'b0);
    check("frame_err_cleared", bus_a.err_count, 0);
    fork
      begin
        send_frame(8'h41, 1'b0, 4);
        send_frame(8'h42, 1'b1, 0);
        send_frame(8'h43, 1'b1, 0);
        send_frame(8'h44, 1'b1, 0);
      end
      wait_done(1'b0, 1000, cyc, seen);
    join
    check("frame_done_seen", seen, 1);
    check("frame_err", bus_a.err_count, 1);
    check("frame_pass", bus_a.pass, 0);
    repeat (200) tick();

    // Missing echo: rx held idle
    rx_drv = 1'b1;
    pulse_start(1'b0);
`ifdef UART_ECHO_TIMEOUT_EN
    wait_done(1'b0, 5000, cyc, seen);
    check("wd_done_seen", seen, 1);
    check("wd_done_cycle", cyc, 4096);
    check("wd_timeout", bus_a.timeout, 1);
    check("wd_pass", bus_a.pass, 0);
    check("wd_busy", bus_a.busy, 0);
    check("wd_err", bus_a.err_count, 0);
`else
    extra = 0;
    repeat (5000) begin
      tick();
      if (bus_a.done) extra++;
    end
    check("noecho_no_done", extra, 0);
    check("noecho_busy", bus_a.busy, 1);
    check("noecho_timeout", bus_a.timeout, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    repeat (20) tick();

    // Reset in the middle of byte 1, then a clean run
    loop_a = 1'b1;
    pulse_start(1'b0);
    repeat (250) tick();
    check("pre_rst_tx_low", bus_a.tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", bus_a.tx, 1);
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_err", bus_a.err_count, 0);
    check("midrst_done", bus_a.done, 0);
    tick();
    rst_n = 1'b1;
    repeat (200) tick();
    tx_seen.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 1000, cyc, seen);
    check("after_rst_done_seen", seen, 1);
    check("after_rst_pass", bus_a.pass, 1);
    check("after_rst_err", bus_a.err_count, 0);
    tick();
    repeat (20) tick();
    check_tx_bytes();

    // Pattern wrap FE, FF, 00 on the second instance
    pulse_start(1'b1);
    check("wrap_busy", bus_b.busy, 1);
    wait_done(1'b1, 1000, cyc, seen);
    check("wrap_done_seen", seen, 1);
    check("wrap_pass", bus_b.pass, 1);
    check("wrap_err", bus_b.err_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
